// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard: a per-register countdown that holds IF/ID until a load result can be forwarded.
// Optional stall performance counter is built only when HAZARD_STALL_CNT_EN is defined.
module hazard_scoreboard #(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [31:0]      id_inst,
    input  logic             mem_busy,
    input  logic             flush,
    output logic             stall,
    output logic             issue,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int CW = ($clog2(LOAD_LAT + 1) > 1) ? $clog2(LOAD_LAT + 1) : 1;
    localparam logic [CW-1:0] LAT_V = CW'(LOAD_LAT);

    logic [5:0]    op;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [15:0]   unusedImm;
    logic          isLoad;
    logic          usesRs;
    logic          usesRt;
    logic          rsBusy;
    logic          rtBusy;
    logic          hazard;
    logic [CW-1:0] entry_q [32];
    logic [CW-1:0] entry_d [32];

    assign op        = id_inst[31:26];
    assign rs        = id_inst[25:21];
    assign rt        = id_inst[20:16];
    assign unusedImm = id_inst[15:0];

    always_comb begin
        isLoad = 1'b0;
        usesRs = 1'b1;
        usesRt = 1'b0;
        case (op)
            6'b100011, 6'b100000: isLoad = 1'b1;
            6'b000000, 6'b101011, 6'b101000, 6'b000100, 6'b000101: usesRt = 1'b1;
            6'b000010, 6'b000011: usesRs = 1'b0;
            default: ;
        endcase
    end

    // $zero is never recorded, but the explicit check keeps it hazard-free by construction.
    assign rsBusy = (rs != 5'd0) && (entry_q[rs] != '0);
    assign rtBusy = (rt != 5'd0) && (entry_q[rt] != '0);
    assign hazard = id_valid & ((usesRs & rsBusy) | (usesRt & rtBusy));
    assign stall  = ~flush & (mem_busy | hazard);
    assign issue  = id_valid & ~flush & ~stall;

    // A new load to the same register restarts its countdown, overriding the decrement.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            entry_d[i] = entry_q[i];
            if (!mem_busy && entry_q[i] != '0) begin
                entry_d[i] = entry_q[i] - CW'(1);
            end
        end
        if (issue && isLoad && rt != 5'd0 && LOAD_LAT > 0) begin
            entry_d[rt] = LAT_V;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Only hazard stalls are counted; memory back-pressure is not, and the count saturates.
    always_comb begin
        cnt_d = cnt_q;
        if (hazard && !mem_busy && !flush && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: two instances (LOAD_LAT=1, LOAD_LAT=3 with a 4-bit counter) share stimulus
// and are checked against a progress-based reference model of when each register's load result becomes ready.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        idValid = 1'b0;
    logic [31:0] idInst = 32'h0;
    logic        memBusy = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  stallO;
    logic [1:0]  issueO;
    logic [15:0] cntA;
    logic [3:0]  cntB;

    int nCompared = 0;
    int nMismatched = 0;

    // Model: prog counts non-busy edges; a register is busy while its ready point lies ahead of prog.
    int lat [2] = '{1, 3};
    int cntMax [2] = '{65535, 15};
    int ready [2][32];
    int cntModel [2] = '{0, 0};
    int prog = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.LOAD_LAT(1), .CNT_W(16)) dutA (
        .clk(clk), .rst_n(rst_n), .id_valid(idValid), .id_inst(idInst), .mem_busy(memBusy),
        .flush(flush), .stall(stallO[0]), .issue(issueO[0]), .stall_cnt(cntA)
    );

    hazard_scoreboard #(.LOAD_LAT(3), .CNT_W(4)) dutB (
        .clk(clk), .rst_n(rst_n), .id_valid(idValid), .id_inst(idInst), .mem_busy(memBusy),
        .flush(flush), .stall(stallO[1]), .issue(issueO[1]), .stall_cnt(cntB)
    );

    function automatic logic [31:0] encLw(input int rt, input int rs);
        logic [4:0] t = 5'(rt);
        logic [4:0] s = 5'(rs);
        return {6'b100011, s, t, 16'h0};
    endfunction

    function automatic logic [31:0] encAdd(input int rd, input int rs, input int rt);
        logic [4:0] d = 5'(rd);
        logic [4:0] s = 5'(rs);
        logic [4:0] t = 5'(rt);
        return {6'b000000, s, t, d, 5'b0, 6'b100000};
    endfunction

    function automatic logic [31:0] encSw(input int rt, input int rs);
        logic [4:0] t = 5'(rt);
        logic [4:0] s = 5'(rs);
        return {6'b101011, s, t, 16'h4};
    endfunction

    function automatic logic [31:0] encJ(input int rsField);
        logic [4:0] s = 5'(rsField);
        return {6'b000010, s, 21'h0};
    endfunction

    function automatic bit mIsLoad();
        return idInst[31:26] == 6'b100011 || idInst[31:26] == 6'b100000;
    endfunction

    function automatic bit mHazard(input int d);
        logic [5:0] op = idInst[31:26];
        int rs = int'(idInst[25:21]);
        int rt = int'(idInst[20:16]);
        bit usesRs = !(op == 6'b000010 || op == 6'b000011);
        bit usesRt = (op == 6'b000000 || op == 6'b101011 || op == 6'b101000 ||
                      op == 6'b000100 || op == 6'b000101);
        bit hz = (usesRs && rs != 0 && ready[d][rs] > prog) ||
                 (usesRt && rt != 0 && ready[d][rt] > prog);
        return idValid && hz;
    endfunction

    function automatic bit mStall(input int d);
        return !flush && (memBusy || mHazard(d));
    endfunction

    function automatic bit mIssue(input int d);
        return idValid && !flush && !mStall(d);
    endfunction

    function automatic int expCnt(input int d);
`ifdef HAZARD_STALL_CNT_EN
        return cntModel[d];
`else
        return (d < 0) ? 1 : 0;
`endif
    endfunction

    function automatic int gotCnt(input int d);
        return (d == 0) ? int'(cntA) : int'(cntB);
    endfunction

    // Reference model advances on the same edges the DUT samples.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                for (int r = 0; r < 32; r++) ready[d][r] = 0;
                cntModel[d] = 0;
            end
        end else if (!memBusy) begin
            for (int d = 0; d < 2; d++) begin
                if (mHazard(d) && !flush)
                    cntModel[d] = (cntModel[d] < cntMax[d]) ? cntModel[d] + 1 : cntMax[d];
                if (mIssue(d) && mIsLoad() && idInst[20:16] != 5'd0 && lat[d] > 0)
                    ready[d][int'(idInst[20:16])] = prog + 1 + lat[d];
            end
            prog = prog + 1;
        end
    end

    task automatic applyStimulus(input bit v, input logic [31:0] inst, input bit busy, input bit fl);
        @(posedge clk);
        #1;
        idValid = v;
        idInst = inst;
        memBusy = busy;
        flush = fl;
        @(negedge clk);
    endtask

    task automatic resetPulse();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        idValid = 1'b0;
        memBusy = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bit es, ei;
        #1 rst_n = 1'b0;
        idInst = encAdd(3, 2, 4);
        for (int k = 0; k < 8; k++) begin
            idValid = k[0];
            memBusy = k[1];
            flush = k[2];
            #2;
            es = k[1] && !k[2];
            ei = k[0] && !k[2] && !es;
            for (int d = 0; d < 2; d++) begin
                nCompared++;
                if (stallO[d] !== es || issueO[d] !== ei) begin
                    nMismatched++;
                    $display("[TB] FAIL reset_outputs dut%0d k=%0d: stall=%b issue=%b, required stall=%b issue=%b",
                             d, k, stallO[d], issueO[d], es, ei);
                end
            end
        end
        nCompared++;
        if (cntA !== 16'd0 || cntB !== 4'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_counter: cntA=%0d cntB=%0d, required 0 and 0", cntA, cntB);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idValid = 1'b0;
        memBusy = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_load_use();
        int stalls [2] = '{0, 0};
        bit issued [2] = '{0, 0};
        int reqStalls [2] = '{1, 3};
        applyStimulus(1, encLw(2, 1), 0, 0);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1, encAdd(3, 2, 4), 0, 0);
            for (int d = 0; d < 2; d++) begin
                nCompared++;
                if (stallO[d] !== mStall(d) || issueO[d] !== mIssue(d)) begin
                    nMismatched++;
                    $display("[TB] FAIL load_use_cycle dut%0d c=%0d: stall=%b issue=%b, required stall=%b issue=%b",
                             d, c, stallO[d], issueO[d], mStall(d), mIssue(d));
                end
                if (!issued[d] && stallO[d] === 1'b1) stalls[d]++;
                if (issueO[d] === 1'b1) issued[d] = 1'b1;
            end
        end
        for (int d = 0; d < 2; d++) begin
            nCompared++;
            if (stalls[d] != reqStalls[d] || !issued[d]) begin
                nMismatched++;
                $display("[TB] FAIL load_use_len dut%0d: stalled %0d cycles issued=%b, required %0d then issue",
                         d, stalls[d], issued[d], reqStalls[d]);
            end
        end
        repeat (4) applyStimulus(0, 32'h0, 0, 0);
        applyStimulus(1, encLw(2, 1), 0, 0);
        applyStimulus(1, encAdd(3, 5, 4), 0, 0);
        for (int d = 0; d < 2; d++) begin
            nCompared++;
            if (stallO[d] !== 1'b0 || issueO[d] !== 1'b1) begin
                nMismatched++;
                $display("[TB] FAIL independent_add dut%0d: stall=%b issue=%b, required stall=0 issue=1",
                         d, stallO[d], issueO[d]);
            end
        end
        repeat (4) applyStimulus(0, 32'h0, 0, 0);
    endtask

    task automatic test_mem_busy();
        int stalls [2] = '{0, 0};
        bit issued [2] = '{0, 0};
        int reqStalls [2] = '{3, 5};
        applyStimulus(1, encLw(7, 1), 0, 0);
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1, encSw(7, 8), (c == 1 || c == 2), 0);
            for (int d = 0; d < 2; d++) begin
                nCompared++;
                if (stallO[d] !== mStall(d) || issueO[d] !== mIssue(d)) begin
                    nMismatched++;
                    $display("[TB] FAIL busy_cycle dut%0d c=%0d: stall=%b issue=%b, required stall=%b issue=%b",
                             d, c, stallO[d], issueO[d], mStall(d), mIssue(d));
                end
                if (!issued[d] && stallO[d] === 1'b1) stalls[d]++;
                if (issueO[d] === 1'b1) issued[d] = 1'b1;
            end
        end
        for (int d = 0; d < 2; d++) begin
            nCompared++;
            if (stalls[d] != reqStalls[d] || !issued[d]) begin
                nMismatched++;
                $display("[TB] FAIL busy_stretch dut%0d: stalled %0d cycles issued=%b, required %0d then issue",
                         d, stalls[d], issued[d], reqStalls[d]);
            end
        end
        repeat (4) applyStimulus(0, 32'h0, 0, 0);
    endtask

    task automatic test_zero_and_jump();
        applyStimulus(1, encLw(0, 1), 0, 0);
        applyStimulus(1, encAdd(3, 0, 0), 0, 0);
        for (int d = 0; d < 2; d++) begin
            nCompared++;
            if (stallO[d] !== 1'b0 || issueO[d] !== 1'b1) begin
                nMismatched++;
                $display("[TB] FAIL reg_zero dut%0d: stall=%b issue=%b, required stall=0 issue=1",
                         d, stallO[d], issueO[d]);
            end
        end
        applyStimulus(1, encLw(2, 1), 0, 0);
        applyStimulus(1, encJ(2), 0, 0);
        for (int d = 0; d < 2; d++) begin
            nCompared++;
            if (stallO[d] !== 1'b0 || issueO[d] !== 1'b1) begin
                nMismatched++;
                $display("[TB] FAIL jump_rs_field dut%0d: stall=%b issue=%b, required stall=0 issue=1",
                         d, stallO[d], issueO[d]);
            end
        end
        repeat (4) applyStimulus(0, 32'h0, 0, 0);
    endtask

    task automatic test_flush();
        int stalls [2] = '{0, 0};
        bit issued [2] = '{0, 0};
        int reqStalls [2] = '{0, 1};
        applyStimulus(1, encLw(7, 1), 0, 0);
        applyStimulus(1, encSw(7, 8), 0, 0);
        applyStimulus(1, encSw(7, 8), 0, 1);
        for (int d = 0; d < 2; d++) begin
            nCompared++;
            if (stallO[d] !== 1'b0 || issueO[d] !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL flush_cycle dut%0d: stall=%b issue=%b, required stall=0 issue=0",
                         d, stallO[d], issueO[d]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1, encAdd(9, 7, 0), 0, 0);
            for (int d = 0; d < 2; d++) begin
                if (!issued[d] && stallO[d] === 1'b1) stalls[d]++;
                if (issueO[d] === 1'b1) issued[d] = 1'b1;
            end
        end
        for (int d = 0; d < 2; d++) begin
            nCompared++;
            if (stalls[d] != reqStalls[d] || !issued[d]) begin
                nMismatched++;
                $display("[TB] FAIL flush_remaining dut%0d: stalled %0d cycles issued=%b, required %0d then issue",
                         d, stalls[d], issued[d], reqStalls[d]);
            end
        end
        repeat (4) applyStimulus(0, 32'h0, 0, 0);
    endtask

    task automatic test_reset_mid();
        applyStimulus(1, encLw(7, 1), 0, 0);
        applyStimulus(1, encSw(7, 8), 0, 0);
        applyStimulus(1, encSw(7, 8), 0, 0);
        nCompared++;
        if (stallO[1] !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL pre_reset_stall: stall=%b, required 1", stallO[1]);
        end
        rst_n = 1'b0;
        #1;
        nCompared++;
        if (stallO[1] !== 1'b0 || issueO[1] !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL async_clear: stall=%b issue=%b, required stall=0 issue=1", stallO[1], issueO[1]);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            nCompared++;
            if (stallO[d] !== 1'b0 || issueO[d] !== 1'b1) begin
                nMismatched++;
                $display("[TB] FAIL post_reset_issue dut%0d: stall=%b issue=%b, required stall=0 issue=1",
                         d, stallO[d], issueO[d]);
            end
        end
        repeat (2) applyStimulus(0, 32'h0, 0, 0);
    endtask

    task automatic test_random();
        logic [5:0] ops [11] = '{6'b100011, 6'b100000, 6'b000000, 6'b101011, 6'b101000, 6'b000100,
                                 6'b000101, 6'b000010, 6'b000011, 6'b001000, 6'b001101};
        logic [31:0] inst;
        for (int c = 0; c < 400; c++) begin
            inst = {ops[$urandom_range(0, 10)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    16'($urandom)};
            applyStimulus($urandom_range(0, 99) < 85, inst, $urandom_range(0, 99) < 15,
                          $urandom_range(0, 99) < 10);
            for (int d = 0; d < 2; d++) begin
                nCompared++;
                if (stallO[d] !== mStall(d) || issueO[d] !== mIssue(d) || gotCnt(d) != expCnt(d)) begin
                    nMismatched++;
                    $display("[TB] FAIL random dut%0d c=%0d: stall=%b issue=%b cnt=%0d, required stall=%b issue=%b cnt=%0d",
                             d, c, stallO[d], issueO[d], gotCnt(d), mStall(d), mIssue(d), expCnt(d));
                end
            end
        end
        repeat (4) applyStimulus(0, 32'h0, 0, 0);
    endtask

    task automatic test_stall_counter();
        int tally = 0;
        int guard = 0;
        bit needLoad = 1'b1;
        int reqA;
        int reqB;
        resetPulse();
        while (tally < 20 && guard < 200) begin
            guard++;
            if (needLoad) begin
                applyStimulus(1, encLw(5, 1), 0, 0);
                needLoad = 1'b0;
            end else begin
                applyStimulus(1, encAdd(6, 5, 5), 0, 0);
                if (stallO[1] === 1'b1) tally++;
                if (issueO[1] === 1'b1) needLoad = 1'b1;
            end
        end
        nCompared++;
        if (tally < 20) begin
            nMismatched++;
            $display("[TB] FAIL counter_stimulus_timeout: saw %0d hazard stalls, required 20", tally);
        end
        applyStimulus(0, 32'h0, 0, 0);
`ifdef HAZARD_STALL_CNT_EN
        reqA = 7;
        reqB = 15;
`else
        reqA = 0;
        reqB = 0;
`endif
        nCompared++;
        if (int'(cntB) != reqB) begin
            nMismatched++;
            $display("[TB] FAIL counter_saturate: stall_cnt=%0d, required %0d", cntB, reqB);
        end
        nCompared++;
        if (int'(cntA) != reqA) begin
            nMismatched++;
            $display("[TB] FAIL counter_wide: stall_cnt=%0d, required %0d", cntA, reqA);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_load_use();
        test_mem_busy();
        test_zero_and_jump();
        test_flush();
        test_reset_mid();
        test_random();
        test_stall_counter();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Load-use hazard detector for the 5-stage MIPS pipeline, replacing the single-cycle combinational compare with a per-register countdown scoreboard. It sits beside the ID stage, watches the instruction in decode, records every load issued to EX, and holds IF/ID for exactly as many cycles as the configured load latency requires. It also absorbs data-memory back-pressure and decode flushes, and optionally counts hazard stall cycles for performance analysis.

## Interface
- LOAD_LAT, 1: cycles a load result is unavailable for forwarding after the load leaves ID; range 0..7; 0 means no load-use stalls.
- CNT_W, 16: width of the stall performance counter.
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- id_valid  input  1  id_inst holds a real instruction.
- id_inst  input  32  instruction currently in ID (IF_ID register).
- mem_busy  input  1  data memory not ready; whole pipeline holds.
- flush  input  1  instruction in ID is being discarded (taken branch/jump).
- stall  output  1  hold PC and IF_ID, insert bubble into ID_EX.
- issue  output  1  ID instruction advances to EX this cycle.
- stall_cnt  output  CNT_W  hazard stall cycles since reset (only with macro).

## Operation
- Decode fields: op=id_inst[31:26], rs=[25:21], rt=[20:16].
- Load: op 100011 (lw) or 100000 (lb); destination rt.
- Source usage:
  - op 000000 (R-type), 101011 (sw), 101000 (sb), 000100 (beq), 000101 (bne): rs and rt.
  - op 000010/000011 (j/jal): none.
  - All other opcodes: rs only.
- Register 0 never creates a hazard and is never recorded.
- Scoreboard: 32 entries, each CW = max(1, clog2(LOAD_LAT+1)) bits. busy(r) = entry r != 0.
- hazard = id_valid & ((rs used & busy(rs)) | (rt used & busy(rt))).
- stall = ~flush & (mem_busy | hazard).
- issue = id_valid & ~flush & ~stall.
- Per-edge update, priority top-down:
  - mem_busy=1: all entries frozen.
  - Otherwise, every nonzero entry decrements by 1.
  - If issue and the instruction is a load with rt != 0, entry rt <= LOAD_LAT. This overrides the decrement of the same entry.
- flush does not touch the scoreboard; older loads remain in flight.
- LOAD_LAT=0: entries are never set; stall = ~flush & mem_busy.
- Reset: all entries 0, stall_cnt 0.
- Outputs during reset: stall = mem_busy & ~flush, issue follows its equation (combinational, no hazards).

## Timing
- stall and issue are combinational from id_inst, id_valid, mem_busy, flush and the registered scoreboard. No added latency.
- A load issuing at edge E makes a dependent instruction in ID stall for exactly LOAD_LAT cycles after E, provided mem_busy=0. Each mem_busy cycle extends the stall by one cycle.
- A back-to-back load to the same rt restarts the countdown at LOAD_LAT.
- Reset asserted mid-countdown clears all entries immediately (asynchronous). The first cycle after release has no hazard.
- stall_cnt increments on each edge where hazard & ~mem_busy & ~flush. It saturates at all-ones.

## Configuration
- HAZARD_STALL_CNT_EN defined: stall_cnt counter is implemented as described.
- HAZARD_STALL_CNT_EN undefined: no counter register; stall_cnt is tied to 0. All other behaviour is identical.

## Test plan
- LOAD_LAT=1: lw $2,0($1), then add $3,$2,$4. Required: stall=1 for one cycle, issue of add one cycle later. No stall if add uses $5,$4.
- LOAD_LAT=3: lw $7, then sw $7,4($8). Required: stall high for exactly 3 cycles. With mem_busy=1 for 2 cycles during the countdown, stall lasts 5 cycles.
- lw $0,0($1), then add $3,$0,$0. Required: no stall. j with rs field = 2 right after lw $2. Required: no stall.
- Flush in the middle of a stall. Required: stall=0 and issue=0 that cycle. The scoreboard entry still expires on schedule, checked by a later dependent stalling the remaining count.
- rst_n low for one cycle two cycles into a LOAD_LAT=3 countdown. Required: entry clears, dependent issues on the first post-reset cycle.
- HAZARD_STALL_CNT_EN with CNT_W=4: 20 hazard stall cycles. Required: stall_cnt reads 15. With the macro undefined, stall_cnt reads 0.
